wb_commit_monitor: RTL
======================

// Module: wb_commit_monitor
// PURPOSE
//   Commit monitor directly downstream of the cpu's MEM/WB buffer: it consumes the
//   writeback stream (register write enable, dest reg, write data, R0 product/quotient).
//   Every retired register write becomes a time-stamped record in a trace FIFO,
//   drained by the bench over a valid/ready port. Cycle/commit/drop counters are
//   kept, and a halt flushes the FIFO before raising done. Synthesizable; no $display.
// PARAMETERS
//   DATA_W      16  width of register write data and R0 data
//   REG_ADDR_W   4  width of destination register index
//   FIFO_DEPTH   8  trace FIFO entries, power of two, >=2
//   CNT_W       32  width of cycle, commit and drop counters
// PORTS
//   clock          in   1            rising-edge clock
//   reset          in   1            asynchronous, active-low reset
//   wb_reg_write   in   1            MEM/WB register write control (commit strobe)
//   wb_write_reg   in   REG_ADDR_W   destination register of the commit
//   wb_write_data  in   DATA_W       data written to wb_write_reg
//   wb_r0_write    in   1            commit also writes R0 (mul/div second result)
//   wb_r0_data     in   DATA_W       R0 data, meaningful only when wb_r0_write=1
//   cpu_halt       in   1            halt from control unit, level
//   cpu_overflow   in   1            ALU overflow flag, level
//   trace_valid    out  1            FIFO head record is presented
//   trace_ready    in   1            consumer accepts head record this cycle
//   trace_cycle    out  CNT_W        cycle_count value at capture
//   trace_reg      out  REG_ADDR_W   captured wb_write_reg
//   trace_data     out  DATA_W       captured wb_write_data
//   trace_r0_vld   out  1            captured wb_r0_write
//   trace_r0_data  out  DATA_W       captured wb_r0_data (0 when trace_r0_vld=0)
//   cycle_count    out  CNT_W        cycles spent in RUN
//   commit_count   out  CNT_W        records captured (pushed or dropped)
//   drop_count     out  CNT_W        records lost to a full FIFO
//   overflow_seen  out  1            sticky: cpu_overflow sampled high in RUN
//   done           out  1            state==HALTED
// BEHAVIOUR
//   Reset (reset=0, async): state=RUN; FIFO empty; all counters 0; overflow_seen=0.
//     Every output is 0, trace_* included.
//   FSM: RUN -> DRAIN when cpu_halt=1 at a clock edge. DRAIN -> HALTED at the first
//     edge where the FIFO is empty, or when it is empty on entry. HALTED is left only by reset.
//   RUN:
//     - cycle_count +1 each edge.
//     - overflow_seen |= cpu_overflow.
//     - Capture when wb_reg_write=1, including the edge on which cpu_halt rises.
//       The record holds the pre-increment cycle_count.
//     - wb_r0_write with wb_reg_write=0 is ignored.
//   DRAIN/HALTED: no capture; cycle_count frozen; pops continue.
//   Every capture increments commit_count, whether pushed or dropped.
//   Latency: a record captured at edge N shows on trace_* after edge N (next cycle)
//     if the FIFO was empty. trace_* is driven from registered FIFO storage/head pointer.
//   Handshake: a pop occurs when trace_valid & trace_ready. trace_* holds stable
//     while trace_valid=1 and trace_ready=0.
//   Full FIFO, capture with no pop that edge: the record is dropped, drop_count +1,
//     and FIFO contents are unchanged.
//   Full FIFO, capture with a pop the same edge: the capture succeeds and occupancy
//     stays at FIFO_DEPTH.
//   Empty FIFO, capture: pushed. No same-cycle bypass to trace_*.
//   Pointers wrap modulo FIFO_DEPTH. Occupancy uses a log2(DEPTH)+1-bit count.
//   All counters saturate at all-ones and never wrap.
//   Reset asserted mid-operation: immediate return to reset state, pending records discarded.
// TESTING
//   1 Reset low 2 cycles, release, no commits for 5 cycles -> cycle_count=5,
//     trace_valid=0, done=0.
//   2 Commit r3=16'h00A5 at cycle 2, trace_ready=1 -> one cycle later trace_valid=1,
//     trace_reg=3, trace_data=00A5, trace_cycle=2; popped next edge.
//   3 trace_ready=0, 10 back-to-back commits, DEPTH=8 -> 8 held, drop_count=2,
//     commit_count=10. Draining returns the first 8 records in order.
//   4 FIFO full, commit plus pop on the same edge -> drop_count unchanged,
//     occupancy stays 8, new record is last out.
//   5 Commit of mul writing r5=0010 and R0=0003 -> trace_r0_vld=1, trace_r0_data=0003.
//   6 3 records queued, cpu_halt=1, ready=1 -> 3 pops, then done=1,
//     cycle_count frozen; reset low mid-DRAIN -> all outputs 0 at once.

Source files
------------

// File: rtl/wb_commit_monitor.sv
// Commit monitor behind the MEM/WB buffer: time-stamps each retired register write
// into a trace FIFO, keeps run statistics and flushes the FIFO on halt before done.
module wb_commit_monitor #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [DATA_W-1:0]     wb_write_data,
    input  logic                  wb_r0_write,
    input  logic [DATA_W-1:0]     wb_r0_data,
    input  logic                  cpu_halt,
    input  logic                  cpu_overflow,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [CNT_W-1:0]      trace_cycle,
    output logic [REG_ADDR_W-1:0] trace_reg,
    output logic [DATA_W-1:0]     trace_data,
    output logic                  trace_r0_vld,
    output logic [DATA_W-1:0]     trace_r0_data,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      commit_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  overflow_seen,
    output logic                  done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int REC_W = CNT_W + REG_ADDR_W + DATA_W + 1 + DATA_W;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   OCC_ONE  = 1;
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [1:0]        state_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [CNT_W-1:0]  cycle_reg;
    logic [CNT_W-1:0]  commit_reg;
    logic [CNT_W-1:0]  drop_reg;
    logic              overflow_reg;
    logic [REC_W-1:0]  mem [FIFO_DEPTH];

    logic              fifo_full;
    logic              fifo_empty;
    logic              capture;
    logic              pop;
    logic              push;
    logic              drop;
    logic [REC_W-1:0]  rec_in;
    logic [REC_W-1:0]  head_rec;

    assign fifo_full  = (count_reg == OCC_FULL);
    assign fifo_empty = (count_reg == '0);
    assign capture    = (state_reg == ST_RUN) && wb_reg_write;
    assign pop        = !fifo_empty && trace_ready;
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign push       = capture && (!fifo_full || pop);
    assign drop       = capture && fifo_full && !pop;

    assign rec_in = {cycle_reg, wb_write_reg, wb_write_data, wb_r0_write,
                     (wb_r0_write ? wb_r0_data : {DATA_W{1'b0}})};

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= rec_in;
                end
            end
        end
    endgenerate

    // Storage is not reset, so the head is masked until an entry is valid.
    assign head_rec = fifo_empty ? {REC_W{1'b0}} : mem[rd_ptr_reg];

    assign trace_valid   = !fifo_empty;
    assign {trace_cycle, trace_reg, trace_data, trace_r0_vld, trace_r0_data} = head_rec;
    assign cycle_count   = cycle_reg;
    assign commit_count  = commit_reg;
    assign drop_count    = drop_reg;
    assign overflow_seen = overflow_reg;
    assign done          = (state_reg == ST_HALTED);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_RUN;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            cycle_reg    <= '0;
            commit_reg   <= '0;
            drop_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (push && !pop) begin
                count_reg <= count_reg + OCC_ONE;
            end else if (pop && !push) begin
                count_reg <= count_reg - OCC_ONE;
            end

            if (capture && (commit_reg != CNT_MAX)) begin
                commit_reg <= commit_reg + CNT_ONE;
            end
            if (drop && (drop_reg != CNT_MAX)) begin
                drop_reg <= drop_reg + CNT_ONE;
            end

            case (state_reg)
                ST_RUN: begin
                    if (cycle_reg != CNT_MAX) begin
                        cycle_reg <= cycle_reg + CNT_ONE;
                    end
                    overflow_reg <= overflow_reg | cpu_overflow;
                    if (cpu_halt) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_reg <= ST_HALTED;
                    end
                end
                default: state_reg <= ST_HALTED;
            endcase
        end
    end
endmodule
